axis_cmd_arbiter: RTL

- Shares the single processor command input (axis_processor s_axis) between NUM_SRC independent AXI-Stream command masters, e.g. host DMA and an on-chip stimulus generator.
- Arbitrates at frame granularity. A frame is zero or more non-terminating commands (AS, apply_periodic, other) closed by a terminating command (RUN or CLR). Frames from different sources never interleave.
- Output is a registered AXIS stage that drives the processor directly.

---
 rtl/processor_config.sv | 14 +
 rtl/axis_cmd_arbiter_rr_arbiter.sv | 20 ++
 rtl/axis_cmd_arbiter.sv | 93 +++++++++
 3 files changed

// File: rtl/processor_config.sv
// processor_config: shared command width, opcode encoding and frame-terminator decode
package processor_config;
    localparam int INP_WIDTH = 16;
    typedef logic [2:0] opcode_t;
    localparam opcode_t OP_RUN = 3'b001;
    localparam opcode_t OP_AS  = 3'b010;
    localparam opcode_t OP_CLR = 3'b011;
    typedef enum logic {ST_IDLE, ST_LOCKED} arb_state_t;
    function automatic logic is_terminator(input logic [INP_WIDTH-1:0] cmd);
        opcode_t op;
        op = cmd[INP_WIDTH-1 -: 3];
        return (op == OP_RUN) || (op == OP_CLR);
    endfunction
endpackage

// File: rtl/axis_cmd_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin one-hot pick of the first request at or above i_ptr
// Ports: i_req request vector, i_ptr priority start index (< N), o_gnt one-hot grant (zero when no request)
module rr_arbiter #(
    parameter int N   = 2,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt
);
    logic [N-1:0] w_mask, w_hi, w_pick;
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < N; i++) w_mask[i] = i >= int'(i_ptr);
    end
    // Requests at or above the pointer win; otherwise wrap to the lowest request.
    assign w_hi   = i_req & w_mask;
    assign w_pick = |w_hi ? w_hi : i_req;
    assign o_gnt  = w_pick & (~w_pick + N'(1));
endmodule

// File: rtl/axis_cmd_arbiter.sv
// axis_cmd_arbiter: frame-granular round-robin sharing of one processor command input among NUM_SRC AXIS masters
// Ports: s_axis_* per-source commands (source i at [i*INP_WIDTH +: INP_WIDTH]),
//        m_axis_* registered command stream to the processor,
//        grant one-hot current owner (zero when idle), timeout_err one-cycle pulse on idle revocation.
module axis_cmd_arbiter
    import processor_config::*;
#(
    parameter int NUM_SRC      = 2,
    parameter int IDLE_TIMEOUT = 1024,
    localparam int CW          = $clog2(IDLE_TIMEOUT + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_SRC*INP_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_SRC-1:0]           s_axis_tvalid,
    output logic [NUM_SRC-1:0]           s_axis_tready,
    output logic [INP_WIDTH-1:0]         m_axis_tdata,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic [NUM_SRC-1:0]           grant,
    output logic                         timeout_err
);
    localparam int PW = $clog2(NUM_SRC);
    arb_state_t           r_state, w_state_nxt;
    logic [NUM_SRC-1:0]   r_grant, w_sel;
    logic [PW-1:0]        r_ptr, w_gidx, w_ptr_nxt;
    logic [CW-1:0]        r_cnt;
    logic [INP_WIDTH-1:0] r_tdata, w_gdata;
    logic                 r_tvalid, r_terr;
    logic                 w_locked, w_gvalid, w_out_rdy, w_acc, w_tmo, w_release;

    rr_arbiter #(.N(NUM_SRC)) u_rr (
        .i_req (s_axis_tvalid),
        .i_ptr (r_ptr),
        .o_gnt (w_sel)
    );

    always_comb begin
        w_gdata = '0;
        w_gidx  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (r_grant[i]) begin
                w_gdata = s_axis_tdata[i*INP_WIDTH +: INP_WIDTH];
                w_gidx  = PW'(i);
            end
        end
    end

    assign w_locked  = r_state == ST_LOCKED;
    assign w_gvalid  = |(s_axis_tvalid & r_grant);
    assign w_out_rdy = !r_tvalid || m_axis_tready;
    assign w_acc     = w_locked && w_gvalid && w_out_rdy;
    // Timeout only fires on a cycle the owner is not valid, so it can never meet an acceptance.
    assign w_tmo     = w_locked && !w_gvalid && (r_cnt == CW'(IDLE_TIMEOUT - 1));
    assign w_release = (w_acc && is_terminator(w_gdata)) || w_tmo;
    assign w_ptr_nxt = (w_gidx == PW'(NUM_SRC - 1)) ? '0 : w_gidx + PW'(1);

    always_ff @(posedge clk) begin
        r_state <= rst ? ST_IDLE : w_state_nxt;
    end

    always_comb begin
        w_state_nxt = (r_state == ST_IDLE) ? (|s_axis_tvalid ? ST_LOCKED : ST_IDLE)
                                           : (w_release ? ST_IDLE : ST_LOCKED);
    end

    always_comb begin
        s_axis_tready = (w_locked && w_out_rdy) ? r_grant : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant  <= '0;
            r_ptr    <= '0;
            r_cnt    <= '0;
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
            r_terr   <= 1'b0;
        end else begin
            r_grant  <= !w_locked ? w_sel : (w_release ? '0 : r_grant);
            r_ptr    <= w_release ? w_ptr_nxt : r_ptr;
            r_cnt    <= (w_locked && !w_gvalid && !w_tmo) ? r_cnt + CW'(1) : '0;
            r_tdata  <= w_acc ? w_gdata : r_tdata;
            r_tvalid <= w_acc || (r_tvalid && !m_axis_tready);
            r_terr   <= w_tmo;
        end
    end

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign grant         = r_grant;
    assign timeout_err   = r_terr;
endmodule
